axlen_partition_mch: RTL and testbench

//  Multi-channel DMA burst partitioner for the AXI master interface (AW or AR side).

---
 rtl/axlen_partition_mch_if.sv | 33 +++
 rtl/axlen_partition_mch.sv | 190 +++++++++++++++++++
 tb/tb_axlen_partition_mch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axlen_partition_mch_if.sv
// AXI address-request channel (AW or AR) plus the matching response
// channel (B, or R-last), as seen by the DMA burst partitioner.
interface axlen_partition_mch_if #(
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8
);
    logic [AXI_IW-1:0] axid;
    logic [AXI_AW-1:0] axaddr;
    logic [AXI_LW-1:0] axlen;
    logic [2:0]        axsize;
    logic [1:0]        axburst;
    logic              axvalid;
    logic              axready;
    logic [AXI_IW-1:0] usr_bid;
    logic [1:0]        usr_bresp;
    logic              usr_bvalid;
    logic              usr_bready;

    modport master (
        output axid, axaddr, axlen, axsize, axburst, axvalid,
        input  axready,
        input  usr_bid, usr_bresp, usr_bvalid,
        output usr_bready
    );

    modport slave (
        input  axid, axaddr, axlen, axsize, axburst, axvalid,
        output axready,
        output usr_bid, usr_bresp, usr_bvalid,
        input  usr_bready
    );
endinterface

// File: rtl/axlen_partition_mch.sv
// Multi-channel DMA burst partitioner. Each channel holds one descriptor
// {start address, byte length}, which is cut into INCR bursts of at most BL
// beats that never cross a 4KB page. Channels are round-robin arbitrated
// onto one registered request slot; AXID carries the channel index.
module axlen_partition_mch #(
    parameter int NCH    = 4,
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int BL     = 16,
    parameter int OD     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    cfg_dma_valid,
    output logic [NCH-1:0]    cfg_dma_ready,
    input  logic [NCH*32-1:0] cfg_dma_sa,
    input  logic [NCH*32-1:0] cfg_dma_len,
    input  logic [NCH-1:0]    dma_irq_w1c,
    output logic [NCH-1:0]    dma_irq,
    output logic [NCH*4-1:0]  dma_err,
    axlen_partition_mch_if.master bus
);
    localparam int L  = $clog2(AXI_DW / 8);
    localparam int RW = 32 - L;
    localparam int OW = $clog2(OD + 1);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} ch_state_e;

    ch_state_e         state_q [NCH];
    ch_state_e         state_d [NCH];
    logic [AXI_AW-1:0] addr_q  [NCH];
    logic [RW-1:0]     rem_q   [NCH];
    logic [OW-1:0]     outs_q  [NCH];
    logic [3:0]        err_q   [NCH];
    logic [31:0]       beats   [NCH];

    logic [NCH-1:0] elig, acc, sa_bad, len_bad, inc, dec;
    logic [PW-1:0]  rr_q, gnt_ch, idx, rsp_ch;
    logic           gnt_vld, load_en, do_grant, hs, rsp_hit;

    logic [AXI_IW-1:0] axid_q;
    logic [AXI_AW-1:0] axaddr_q;
    logic [AXI_LW-1:0] axlen_q;
    logic              axvalid_q;

    // Beats in the next burst: bounded by BL, the remaining beats and the
    // distance to the next 4KB page.
    function automatic logic [31:0] burst_beats(input logic [AXI_AW-1:0] addr,
                                                input logic [RW-1:0] rem);
        logic [31:0] b;
        logic [31:0] room;
        room = (32'd4096 - {20'd0, addr[11:0]}) >> L;
        b    = 32'(BL);
        if (32'(rem) < b)  b = 32'(rem);
        if (room < b)      b = room;
        return b;
    endfunction

    assign load_en  = !axvalid_q || bus.axready;
    assign do_grant = load_en && gnt_vld;
    assign hs       = axvalid_q && bus.axready;
    assign rsp_ch   = bus.usr_bid[PW-1:0];
    assign rsp_hit  = bus.usr_bvalid && (32'(bus.usr_bid) < 32'(NCH)) &&
                      (outs_q[rsp_ch] != '0);

    // Per-channel burst size, eligibility, descriptor checks and counter events.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            beats[c]   = burst_beats(addr_q[c], rem_q[c]);
            elig[c]    = (state_q[c] == ST_RUN) && (rem_q[c] != '0) && (outs_q[c] < OW'(OD));
            sa_bad[c]  = cfg_dma_sa[32*c +: L] != '0;
            len_bad[c] = (cfg_dma_len[32*c +: 32] == 32'd0) || (cfg_dma_len[32*c +: L] != '0);
            inc[c]     = do_grant && (gnt_ch == PW'(c));
            dec[c]     = rsp_hit && (rsp_ch == PW'(c));
        end
    end

    // Round-robin: first eligible channel at or after the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = PW'((int'(rr_q) + i) % NCH);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    // Channel FSM next state; a bad descriptor skips straight to DONE.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            acc[c]     = 1'b0;
            unique case (state_q[c])
                ST_IDLE: if (cfg_dma_valid[c]) begin
                    acc[c]     = 1'b1;
                    state_d[c] = (sa_bad[c] || len_bad[c]) ? ST_DONE : ST_RUN;
                end
                ST_RUN:  if (hs && (axid_q == AXI_IW'(c)) && (rem_q[c] == '0))
                    state_d[c] = ST_WAIT;
                ST_WAIT: if (outs_q[c] == '0)
                    state_d[c] = ST_DONE;
                ST_DONE: if (dma_irq_w1c[c])
                    state_d[c] = ST_IDLE;
            endcase
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) state_q[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < NCH; c++) state_q[c] <= state_d[c];
        end
    end

    // Per-channel address, remaining beats, outstanding count and sticky errors;
    // a grant is charged to its channel immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
                outs_q[c] <= '0;
                err_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (acc[c]) begin
                    addr_q[c] <= cfg_dma_sa[32*c +: AXI_AW];
                    rem_q[c]  <= cfg_dma_len[32*c+L +: RW];
                    err_q[c]  <= {2'b00, len_bad[c], sa_bad[c]};
                end else begin
                    if (inc[c]) begin
                        addr_q[c] <= addr_q[c] + (AXI_AW'(beats[c]) << L);
                        rem_q[c]  <= rem_q[c] - RW'(beats[c]);
                    end
                    if (dec[c] && (bus.usr_bresp == 2'b10)) err_q[c][2] <= 1'b1;
                    if (dec[c] && (bus.usr_bresp == 2'b11)) err_q[c][3] <= 1'b1;
                end
                if (inc[c] && !dec[c])      outs_q[c] <= outs_q[c] + OW'(1);
                else if (dec[c] && !inc[c]) outs_q[c] <= outs_q[c] - OW'(1);
            end
        end
    end

    // Request slot: reload on grant whenever it is empty or being accepted,
    // otherwise hold stable until axready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axvalid_q <= 1'b0;
            axid_q    <= '0;
            axaddr_q  <= '0;
            axlen_q   <= '0;
            rr_q      <= '0;
        end else if (do_grant) begin
            axvalid_q <= 1'b1;
            axid_q    <= AXI_IW'(gnt_ch);
            axaddr_q  <= addr_q[gnt_ch];
            axlen_q   <= AXI_LW'(beats[gnt_ch] - 32'd1);
            rr_q      <= PW'((int'(gnt_ch) + 1) % NCH);
        end else if (hs) begin
            axvalid_q <= 1'b0;
        end
    end

    // Status and bus outputs.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cfg_dma_ready[c]   = state_q[c] == ST_IDLE;
            dma_irq[c]         = state_q[c] == ST_DONE;
            dma_err[4*c +: 4]  = err_q[c];
        end
    end

    assign bus.axid       = axid_q;
    assign bus.axaddr     = axaddr_q;
    assign bus.axlen      = axlen_q;
    assign bus.axsize     = 3'(L);
    assign bus.axburst    = 2'b01;
    assign bus.axvalid    = axvalid_q;
    assign bus.usr_bready = 1'b1;
endmodule

// File: tb/tb_axlen_partition_mch.sv
// Directed bench for axlen_partition_mch (NCH=4, 128-bit data, BL=16, OD=4).
module tb_axlen_partition_mch;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    cfg_dma_valid, cfg_dma_ready, dma_irq_w1c, dma_irq;
    logic [NCH*32-1:0] cfg_dma_sa, cfg_dma_len;
    logic [NCH*4-1:0]  dma_err;
    int n_chk  = 0;
    int n_fail = 0;

    axlen_partition_mch_if #(.AXI_AW(32), .AXI_IW(8), .AXI_LW(8)) bus ();

    axlen_partition_mch #(
        .NCH(NCH), .AXI_DW(128), .AXI_AW(32), .AXI_IW(8),
        .AXI_LW(8), .BL(16), .OD(4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_dma_valid (cfg_dma_valid),
        .cfg_dma_ready (cfg_dma_ready),
        .cfg_dma_sa    (cfg_dma_sa),
        .cfg_dma_len   (cfg_dma_len),
        .dma_irq_w1c   (dma_irq_w1c),
        .dma_irq       (dma_irq),
        .dma_err       (dma_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input int ch, input logic [31:0] sa, input logic [31:0] len);
        cfg_dma_valid[ch]       = 1'b1;
        cfg_dma_sa[32*ch +: 32]  = sa;
        cfg_dma_len[32*ch +: 32] = len;
        tick();
        cfg_dma_valid = '0;
    endtask

    task automatic take_burst(input string tag, input logic [7:0] eid,
                              input logic [31:0] eaddr, input logic [7:0] elen);
        int n = 0;
        while (!bus.axvalid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_vld"},  bus.axvalid, 1);
        chk({tag, "_id"},   bus.axid,    eid);
        chk({tag, "_addr"}, bus.axaddr,  eaddr);
        chk({tag, "_len"},  bus.axlen,   elen);
        bus.axready = 1'b1;
        tick();
        bus.axready = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] id, input logic [1:0] resp);
        bus.usr_bvalid = 1'b1;
        bus.usr_bid    = id;
        bus.usr_bresp  = resp;
        tick();
        bus.usr_bvalid = 1'b0;
    endtask

    task automatic w1c(input int ch);
        dma_irq_w1c[ch] = 1'b1;
        tick();
        dma_irq_w1c = '0;
    endtask

    initial begin
        int got;
        cfg_dma_valid  = '0;
        cfg_dma_sa     = '0;
        cfg_dma_len    = '0;
        dma_irq_w1c    = '0;
        bus.axready    = 1'b0;
        bus.usr_bvalid = 1'b0;
        bus.usr_bid    = '0;
        bus.usr_bresp  = '0;
        do_reset();

        // Reset values
        chk("rst_ready",   cfg_dma_ready, 4'hF);
        chk("rst_irq",     dma_irq,       4'h0);
        chk("rst_err",     dma_err,       16'h0);
        chk("rst_axvalid", bus.axvalid,   1'b0);
        chk("rst_axid",    bus.axid,      8'h0);
        chk("rst_axaddr",  bus.axaddr,    32'h0);
        chk("rst_axlen",   bus.axlen,     8'h0);
        chk("axsize",      bus.axsize,    3'd4);
        chk("axburst",     bus.axburst,   2'b01);
        chk("bready",      bus.usr_bready, 1'b1);

        // Simple two-burst descriptor
        cfg(0, 32'h1000, 32'h200);
        chk("t1_busy", cfg_dma_ready, 4'hE);
        take_burst("t1_b0", 8'd0, 32'h1000, 8'd15);
        take_burst("t1_b1", 8'd0, 32'h1100, 8'd15);
        send_b(8'd0, 2'b00);
        send_b(8'd0, 2'b00);
        tick();
        chk("t1_irq", dma_irq, 4'h1);
        chk("t1_err", dma_err, 16'h0);
        w1c(0);

        // 4KB page split
        cfg(0, 32'h1FC0, 32'h100);
        take_burst("t2_b0", 8'd0, 32'h1FC0, 8'd3);
        take_burst("t2_b1", 8'd0, 32'h2000, 8'd11);
        send_b(8'd0, 2'b01);
        send_b(8'd0, 2'b00);
        tick();
        chk("t2_irq", dma_irq, 4'h1);
        chk("t2_ready_done", cfg_dma_ready, 4'hE);
        w1c(0);
        chk("t2_ready_w1c", cfg_dma_ready, 4'hF);
        chk("t2_irq_clr", dma_irq, 4'h0);

        // Round-robin between two channels, axready held high
        do_reset();
        cfg_dma_valid = 4'b0011;
        cfg_dma_sa    = {32'h0, 32'h0, 32'h8000, 32'h0};
        cfg_dma_len   = {32'h0, 32'h0, 32'h400, 32'h400};
        tick();
        cfg_dma_valid = '0;
        bus.axready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (bus.axvalid) begin
                chk("t3_id",   bus.axid,   8'(got % 2));
                chk("t3_addr", bus.axaddr, 32'((got % 2) * 32'h8000 + (got / 2) * 32'h100));
                chk("t3_len",  bus.axlen,  8'd15);
                got++;
            end
            tick();
        end
        chk("t3_count", got, 8);
        tick();
        chk("t3_idle", bus.axvalid, 1'b0);

        // Outstanding limit with no responses
        do_reset();
        bus.axready = 1'b1;
        cfg(0, 32'h0, 32'h1000);
        got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.axvalid) got++;
            tick();
        end
        chk("t4_od_count", got, 4);
        chk("t4_stalled", bus.axvalid, 1'b0);
        bus.axready = 1'b0;
        send_b(8'd0, 2'b00);
        take_burst("t4_b4", 8'd0, 32'h400, 8'd15);

        // Descriptor errors and error responses
        do_reset();
        cfg(0, 32'h1004, 32'h100);
        chk("t5_sa_irq", dma_irq, 4'h1);
        chk("t5_sa_err", dma_err[3:0], 4'b0001);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_axvalid", bus.axvalid, 1'b0);
            tick();
        end
        cfg(1, 32'h0, 32'h104);
        chk("t5_len_unal", dma_err[7:4], 4'b0010);
        cfg(2, 32'h0, 32'h0);
        chk("t5_len_zero", dma_err[11:8], 4'b0010);
        chk("t5_irqs", dma_irq, 4'h7);
        w1c(0);
        cfg(0, 32'h2000, 32'h10);
        chk("t5_err_cleared", dma_err[3:0], 4'b0000);
        take_burst("t5_b0", 8'd0, 32'h2000, 8'd0);
        send_b(8'd0, 2'b10);
        tick();
        chk("t5_slverr", dma_err[3:0], 4'b0100);
        chk("t5_slv_irq", dma_irq[0], 1'b1);
        cfg(3, 32'h5000, 32'h10);
        take_burst("t5_b3", 8'd3, 32'h5000, 8'd0);
        send_b(8'd3, 2'b11);
        send_b(8'd1, 2'b11);
        send_b(8'd9, 2'b10);
        tick();
        chk("t5_err_all", dma_err, 16'h8224);
        chk("t5_irq_all", dma_irq, 4'hF);

        // Stall: outputs held while axready is low, then async reset
        do_reset();
        cfg(0, 32'h3000, 32'h200);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_vld",  bus.axvalid, 1'b1);
            chk("t6_id",   bus.axid,    8'd0);
            chk("t6_addr", bus.axaddr,  32'h3000);
            chk("t6_len",  bus.axlen,   8'd15);
        end
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_arst_vld",   bus.axvalid,   1'b0);
        chk("t6_arst_addr",  bus.axaddr,    32'h0);
        chk("t6_arst_len",   bus.axlen,     8'h0);
        chk("t6_arst_ready", cfg_dma_ready, 4'hF);
        chk("t6_arst_irq",   dma_irq,       4'h0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("t6_post_vld", bus.axvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
